des_decrypt_engine: RTL and testbench
=====================================

DES_DECRYPT_ENGINE -- requirements
Module: des_decrypt_engine

Interface
REQ-001 The block SHALL have reset reset, synchronous, active-high; clock clk.
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port din_valid, input, 1, ciphertext and key valid.
REQ-005 The block SHALL have port din_ready, output, 1, engine can accept a block.
REQ-006 The block SHALL have port ciphertext_din, input, [0:63], ciphertext in DES bit order, bit 0 = MSB.
REQ-007 The block SHALL have port key_din, input, [0:63], 64-bit DES key with parity bits; parity bits are ignored.
REQ-008 The block SHALL have port dout_valid, output, 1, plaintext_dout holds a result.
REQ-009 The block SHALL have port dout_ready, input, 1, consumer accepts the result.
REQ-010 The block SHALL have port plaintext_dout, output, [0:63], recovered plaintext.

Function
REQ-011 The engine SHALL use an FSM with states IDLE, ROUND and DONE.
REQ-012 The engine SHALL drive din_ready=1 only in IDLE.
REQ-013 In IDLE, when din_valid=1, the engine SHALL accept the input and, in the same cycle:
- register L,R <= IP(ciphertext_din);
- register C,D <= PC1(key_din);
- clear the 4-bit round counter;
- go to ROUND.
REQ-014 In ROUND, each cycle SHALL perform one Feistel round:
- L <= R;
- R <= L ^ P(S(E(R) ^ K));
- K = PC2(C,D) of the current key-schedule state.
REQ-015 The round key order SHALL be K16 down to K1. The first round SHALL use PC2(C0,D0) with no rotation.
REQ-016 After each round, C and D SHALL each rotate right by the decrypt shift schedule: 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 for rounds 1..15; no rotate after round 16. C and D SHALL each wrap within 28 bits.
REQ-017 After round 16 (counter = 15), the engine SHALL register plaintext_dout <= FP({R16,L16}), set dout_valid=1 and go to DONE.
REQ-018 Latency SHALL be 17 cycles from the accept edge to dout_valid=1. Sustained throughput SHALL be one block per 18 cycles with dout_ready held high.
REQ-019 In DONE, plaintext_dout and dout_valid SHALL hold stable until dout_ready=1. On that edge the engine SHALL clear dout_valid and go to IDLE.
REQ-020 The engine SHALL ignore din_valid outside IDLE; the inputs are not sampled.
REQ-021 The engine SHALL ignore dout_ready while dout_valid=0.

Reset
REQ-022 Reset SHALL set the state to IDLE and clear L, R, C, D, the counter, plaintext_dout and dout_valid to 0. din_ready SHALL be 1 on the first cycle after reset.
REQ-023 Reset asserted in ROUND or DONE SHALL abort the block, and no dout_valid pulse SHALL follow.
REQ-024 Reset SHALL take priority over every other event, including a simultaneous accept.

Configuration
REQ-025 With macro DES_ENGINE_ENCRYPT_MODE_EN defined, the engine SHALL have an extra port encrypt_sel, input, 1, sampled at accept. When encrypt_sel=1, the engine SHALL apply the left-rotate schedule 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 before each round, giving key order K1..K16. All other behaviour SHALL be unchanged.
REQ-026 Without DES_ENGINE_ENCRYPT_MODE_EN, the encrypt_sel port and the encrypt logic SHALL be absent, and the engine SHALL decrypt only.

Structure
REQ-027 Package des_pkg SHALL hold:
- the FSM state type;
- the round-count constant 16;
- the 16-entry shift-schedule constant;
- the block-width constant 64, half-width constant 32, round-key-width constant 48 and key-half-width constant 28.
REQ-028 The key schedule (PC1, PC2, C/D registers, rotation) SHALL be sub-module des_key_schedule. It SHALL take load, step and dir inputs and output the 48-bit round key.
REQ-029 The engine SHALL use the existing des_sbox1..des_sbox8 modules for S.

Verification
REQ-030 The bench SHALL run: key 133457799BBCDFF1, ciphertext 85E813540F0AB405 -> plaintext 0123456789ABCDEF, with dout_valid exactly 17 cycles after accept.
REQ-031 The bench SHALL run: key 0E329232EA6D0D73, ciphertext 0000000000000000 -> plaintext 8787878787878787.
REQ-032 The bench SHALL hold dout_ready=0 for 10 cycles in DONE: plaintext_dout stays stable, din_ready=0 and a new din_valid is ignored. When dout_ready=1, dout_valid drops on the next edge.
REQ-033 The bench SHALL assert reset at round 8 during the first vector: all outputs are 0 next cycle with din_ready=1, and no dout_valid appears. A following run of the first vector still yields 0123456789ABCDEF.
REQ-034 The bench SHALL run back-to-back blocks of the REQ-030 then REQ-031 vectors with dout_ready=1: accept edges are 18 cycles apart and both outputs are correct.
REQ-035 With DES_ENGINE_ENCRYPT_MODE_EN defined, the bench SHALL run encrypt_sel=1, key 133457799BBCDFF1, data 0123456789ABCDEF -> 85E813540F0AB405.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES definitions: FSM state type, widths, shift schedule,
// permutation/S-box tables and the permutation helpers built on them.
package des_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam int ROUNDS  = 16;
  localparam int BLOCK_W = 64;
  localparam int HALF_W  = 32;
  localparam int RK_W    = 48;
  localparam int KH_W    = 28;
  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  // Left-rotate amounts for encryption rounds 1..16; decryption walks it backwards.
  localparam logic [1:0] SHIFT [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  // Tables hold 1-based DES bit numbers, bit 1 = MSB.
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                              16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15,7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,
                                26,8,16,7,27,20,13,2,41,52,31,37,47,55,30,40,
                                51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};

  localparam int S_T [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [0:63] des_ip(input logic [0:63] x);
    logic [0:63] y;
    for (int i = 0; i < 64; i++) y[6'(i)] = x[6'(IP_T[6'(i)] - 1)];
    return y;
  endfunction

  function automatic logic [0:63] des_fp(input logic [0:63] x);
    logic [0:63] y;
    for (int i = 0; i < 64; i++) y[6'(i)] = x[6'(FP_T[6'(i)] - 1)];
    return y;
  endfunction

  function automatic logic [0:47] des_e(input logic [0:31] x);
    logic [0:47] y;
    for (int i = 0; i < 48; i++) y[6'(i)] = x[5'(E_T[6'(i)] - 1)];
    return y;
  endfunction

  function automatic logic [0:31] des_p(input logic [0:31] x);
    logic [0:31] y;
    for (int i = 0; i < 32; i++) y[5'(i)] = x[5'(P_T[5'(i)] - 1)];
    return y;
  endfunction

  function automatic logic [0:55] des_pc1(input logic [0:63] x);
    logic [0:55] y;
    for (int i = 0; i < 56; i++) y[6'(i)] = x[6'(PC1_T[6'(i)] - 1)];
    return y;
  endfunction

  function automatic logic [0:47] des_pc2(input logic [0:55] x);
    logic [0:47] y;
    for (int i = 0; i < 48; i++) y[6'(i)] = x[6'(PC2_T[6'(i)] - 1)];
    return y;
  endfunction

  // Row comes from the outer bits, column from the inner four.
  function automatic logic [0:3] des_sbox_lookup(input int k, input logic [0:5] x);
    return 4'(S_T[3'(k)][{x[0], x[5], x[1:4]}]);
  endfunction

  function automatic logic [0:27] rotl28(input logic [0:27] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[1:27], x[0]};
      2'd2:    return {x[2:27], x[0:1]};
      default: return x;
    endcase
  endfunction

  function automatic logic [0:27] rotr28(input logic [0:27] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[27], x[0:26]};
      2'd2:    return {x[26:27], x[0:25]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_key_schedule.sv
// DES key schedule: PC1 on load, one round key per step.
// dir=0 (decrypt): key = PC2(C,D), then rotate right; first key is K16.
// dir=1 (encrypt): rotate left first, key = PC2 of the rotated halves; first key is K1.
module des_key_schedule
  import des_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic              dir,
  input  logic [0:63]       key_din,
  output logic [0:RK_W-1]   round_key
);

  logic [0:KH_W-1] c_q, d_q, c_enc, d_enc;
  logic [3:0]      idx_q;
  logic [1:0]      sh_enc, sh_dec;

  // Rotation amounts and the round key for the current round index.
  always_comb begin
    sh_enc    = SHIFT[idx_q];
    sh_dec    = SHIFT[4'd15 - idx_q];
    c_enc     = rotl28(c_q, sh_enc);
    d_enc     = rotl28(d_q, sh_enc);
    round_key = dir ? des_pc2({c_enc, d_enc}) : des_pc2({c_q, d_q});
  end

  // C/D registers: load from PC1, then advance one round per step.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_q   <= '0;
      d_q   <= '0;
      idx_q <= '0;
    end else if (load) begin
      {c_q, d_q} <= des_pc1(key_din);
      idx_q      <= '0;
    end else if (step) begin
      idx_q <= idx_q + 4'd1;
      if (dir) begin
        c_q <= c_enc;
        d_q <= d_enc;
      end else if (idx_q != LAST_ROUND) begin
        c_q <= rotr28(c_q, sh_dec);
        d_q <= rotr28(d_q, sh_dec);
      end
    end
  end

endmodule

// File: rtl/des_sbox.sv
// The eight DES substitution boxes, 6 bits in, 4 bits out, DES bit order.
module des_sbox1 import des_pkg::*; (input logic [0:5] din, output logic [0:3] dout);
  assign dout = des_sbox_lookup(0, din);
endmodule

module des_sbox2 import des_pkg::*; (input logic [0:5] din, output logic [0:3] dout);
  assign dout = des_sbox_lookup(1, din);
endmodule

module des_sbox3 import des_pkg::*; (input logic [0:5] din, output logic [0:3] dout);
  assign dout = des_sbox_lookup(2, din);
endmodule

module des_sbox4 import des_pkg::*; (input logic [0:5] din, output logic [0:3] dout);
  assign dout = des_sbox_lookup(3, din);
endmodule

module des_sbox5 import des_pkg::*; (input logic [0:5] din, output logic [0:3] dout);
  assign dout = des_sbox_lookup(4, din);
endmodule

module des_sbox6 import des_pkg::*; (input logic [0:5] din, output logic [0:3] dout);
  assign dout = des_sbox_lookup(5, din);
endmodule

module des_sbox7 import des_pkg::*; (input logic [0:5] din, output logic [0:3] dout);
  assign dout = des_sbox_lookup(6, din);
endmodule

module des_sbox8 import des_pkg::*; (input logic [0:5] din, output logic [0:3] dout);
  assign dout = des_sbox_lookup(7, din);
endmodule

// File: rtl/des_decrypt_engine.sv
// Iterative DES engine, one Feistel round per clock, 17-cycle latency.
// Build option: DES_ENGINE_ENCRYPT_MODE_EN adds the encrypt_sel port
// (sampled at accept) selecting encryption key order K1..K16.
module des_decrypt_engine
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [0:63] ciphertext_din,
  input  logic [0:63] key_din,
`ifdef DES_ENGINE_ENCRYPT_MODE_EN
  input  logic        encrypt_sel,
`endif
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [0:63] plaintext_dout
);

  state_t               state_q, state_d;
  logic [0:HALF_W-1]    l_q, r_q, f_out, sout;
  logic [0:RK_W-1]      rk, er;
  logic [0:BLOCK_W-1]   pt_q;
  logic [3:0]           cnt_q;
  logic                 dv_q, load, step, dir;

`ifdef DES_ENGINE_ENCRYPT_MODE_EN
  logic enc_q;

  // Direction is latched with the block so it cannot change mid-run.
  always_ff @(posedge clk) begin
    if (reset)     enc_q <= 1'b0;
    else if (load) enc_q <= encrypt_sel;
  end
  assign dir = enc_q;
`else
  assign dir = 1'b0;
`endif

  des_key_schedule u_ks (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .dir       (dir),
    .key_din   (key_din),
    .round_key (rk)
  );

  assign er = des_e(r_q) ^ rk;

  des_sbox1 u_s1 (.din(er[0:5]),   .dout(sout[0:3]));
  des_sbox2 u_s2 (.din(er[6:11]),  .dout(sout[4:7]));
  des_sbox3 u_s3 (.din(er[12:17]), .dout(sout[8:11]));
  des_sbox4 u_s4 (.din(er[18:23]), .dout(sout[12:15]));
  des_sbox5 u_s5 (.din(er[24:29]), .dout(sout[16:19]));
  des_sbox6 u_s6 (.din(er[30:35]), .dout(sout[20:23]));
  des_sbox7 u_s7 (.din(er[36:41]), .dout(sout[24:27]));
  des_sbox8 u_s8 (.din(er[42:47]), .dout(sout[28:31]));

  assign f_out          = des_p(sout);
  assign dout_valid     = dv_q;
  assign plaintext_dout = pt_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state plus accept / key-step strobes.
  always_comb begin
    state_d   = state_q;
    din_ready = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      IDLE: begin
        din_ready = 1'b1;
        if (din_valid) begin
          load    = 1'b1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        step = 1'b1;
        if (cnt_q == LAST_ROUND) state_d = DONE;
      end
      DONE: begin
        if (dout_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Feistel datapath, round counter and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      l_q   <= '0;
      r_q   <= '0;
      cnt_q <= '0;
      pt_q  <= '0;
      dv_q  <= 1'b0;
    end else begin
      if (load) begin
        {l_q, r_q} <= des_ip(ciphertext_din);
        cnt_q      <= '0;
      end
      if (step) begin
        l_q   <= r_q;
        r_q   <= l_q ^ f_out;
        cnt_q <= cnt_q + 4'd1;
        if (cnt_q == LAST_ROUND) begin
          pt_q <= des_fp({l_q ^ f_out, r_q});
          dv_q <= 1'b1;
        end
      end
      if (state_q == DONE && dout_ready) dv_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_des_decrypt_engine.sv
// Scoreboard bench for des_decrypt_engine: stimulus pushes expected results,
// a negedge monitor pops and compares on each output handshake and checks latency.
module tb_des_decrypt_engine;

  logic        clk = 1'b0;
  logic        reset, din_valid, din_ready, dout_valid, dout_ready;
  logic [0:63] ciphertext_din, key_din, plaintext_dout;
`ifdef DES_ENGINE_ENCRYPT_MODE_EN
  logic        encrypt_sel;
`endif

  localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
  localparam logic [63:0] C1  = 64'h85E813540F0AB405;
  localparam logic [63:0] P1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] C2  = 64'h0000000000000000;
  localparam logic [63:0] P2  = 64'h8787878787878787;

  int          checks = 0, failures = 0, cycp = 0;
  logic [63:0] exp_q [$];
  int          acc_q [$];
  logic        prev_valid = 1'b0;

  des_decrypt_engine dut (
    .clk            (clk),
    .reset          (reset),
    .din_valid      (din_valid),
    .din_ready      (din_ready),
    .ciphertext_din (ciphertext_din),
    .key_din        (key_din),
`ifdef DES_ENGINE_ENCRYPT_MODE_EN
    .encrypt_sel    (encrypt_sel),
`endif
    .dout_valid     (dout_valid),
    .dout_ready     (dout_ready),
    .plaintext_dout (plaintext_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycp <= cycp + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Monitor: latency on each dout_valid rise, data on each output handshake.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      acc_q.delete();
    end else begin
      if (din_valid && din_ready) acc_q.push_back(cycp);
      if (dout_valid && !prev_valid) begin
        if (acc_q.size() == 0) flag("latency_no_accept");
        else check("latency", 64'(cycp - acc_q.pop_front()), 64'd17);
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) flag("unexpected_output");
        else check("plaintext", plaintext_dout, exp_q.pop_front());
      end
    end
    prev_valid = dout_valid;
  end

  task automatic send(input logic [63:0] key, input logic [63:0] data, input logic [63:0] exp);
    bit ok = 0;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    key_din = key;
    ciphertext_din = data;
    din_valid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (din_ready) begin ok = 1; break; end
    end
    if (!ok) flag("accept_timeout");
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (din_ready) begin ok = 1; break; end
    end
    if (!ok) flag("idle_timeout");
  endtask

  initial begin
    int a0, a1, seen;
    bit ok;
    reset = 1'b1; din_valid = 1'b0; dout_ready = 1'b1;
    key_din = '0; ciphertext_din = '0;
`ifdef DES_ENGINE_ENCRYPT_MODE_EN
    encrypt_sel = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_din_ready", 64'(din_ready), 64'd1);
    check("rst_dout_valid", 64'(dout_valid), 64'd0);
    check("rst_plaintext", plaintext_dout, 64'd0);

    // Two single blocks.
    send(K1, C1, P1); wait_idle();
    send(K2, C2, P2); wait_idle();

    // Stall in DONE with a competing din_valid.
    dout_ready = 1'b0;
    send(K1, C1, P1);
    ok = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (dout_valid) begin ok = 1; break; end
    end
    if (!ok) flag("stall_done_timeout");
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      din_valid = 1'b1; key_din = K2; ciphertext_din = C2;
      @(negedge clk);
      check("stall_plaintext", plaintext_dout, P1);
      check("stall_dout_valid", 64'(dout_valid), 64'd1);
      check("stall_din_ready", 64'(din_ready), 64'd0);
    end
    @(posedge clk); #1;
    din_valid = 1'b0; dout_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    check("release_dout_valid", 64'(dout_valid), 64'd0);
    check("release_din_ready", 64'(din_ready), 64'd1);
    repeat (3) @(negedge clk);

    // Reset during round 8 aborts the block.
    send(K1, C1, P1);
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_din_ready", 64'(din_ready), 64'd1);
    check("abort_dout_valid", 64'(dout_valid), 64'd0);
    check("abort_plaintext", plaintext_dout, 64'd0);
    seen = 0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (dout_valid) seen++;
    end
    check("abort_no_output", 64'(seen), 64'd0);
    send(K1, C1, P1); wait_idle();

    // Back-to-back blocks with din_valid held high.
    exp_q.push_back(P1);
    exp_q.push_back(P2);
    a0 = 0; a1 = 0;
    @(posedge clk); #1;
    key_din = K1; ciphertext_din = C1; din_valid = 1'b1;
    ok = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (din_ready) begin ok = 1; a0 = cycp; break; end
    end
    if (!ok) flag("b2b_first_timeout");
    @(posedge clk); #1;
    key_din = K2; ciphertext_din = C2;
    ok = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (din_ready) begin ok = 1; a1 = cycp; break; end
    end
    if (!ok) flag("b2b_second_timeout");
    @(posedge clk); #1;
    din_valid = 1'b0;
    check("b2b_spacing", 64'(a1 - a0), 64'd18);
    wait_idle();

`ifdef DES_ENGINE_ENCRYPT_MODE_EN
    encrypt_sel = 1'b1;
    send(K1, P1, C1);
    encrypt_sel = 1'b0;
    wait_idle();
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
